// File: rtl/spring_fxp_pkg.sv
// spring_fxp_pkg: shared Q(IL.FL) fixed-point types, batch sizing, saturation helper and batch_center states
package spring_fxp_pkg;
  localparam int IL = 8;
  localparam int FL = 12;
  localparam int W = IL + FL;
  localparam int SIZE = 16;
  localparam int NW = $clog2(SIZE) + 1;
  localparam int DIV_CYC = 2 * W;
  typedef logic signed [W-1:0] fxp_t;
  typedef logic signed [2*W-1:0] acc_t;
  typedef enum logic [1:0] {LOAD, DIVIDE, EMIT} bc_state_t;
  localparam fxp_t FXP_MAX = {1'b0, {(W-1){1'b1}}};
  localparam fxp_t FXP_MIN = {1'b1, {(W-1){1'b0}}};
  function automatic fxp_t sat_fxp(input acc_t x);
    return x > acc_t'(FXP_MAX) ? FXP_MAX : x < acc_t'(FXP_MIN) ? FXP_MIN : x[W-1:0];
  endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, 2W-bit dividend by NW-bit divisor, done pulses DIV_CYC cycles after start (ports: start/dividend/divisor in, done/quotient out)
module seq_divider
  import spring_fxp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*W-1:0]  dividend,
  input  logic [NW-1:0]   divisor,
  output logic            done,
  output logic [W-1:0]    quotient
);
  logic [2*W-1:0] q;
  logic [NW-1:0] rem, dv;
  logic [NW:0] sh;
  logic [$clog2(DIV_CYC):0] cnt;
  logic busy, fit;
  always_comb begin
    sh = {rem, q[2*W-1]};
    fit = sh >= {1'b0, dv};
    quotient = q[W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      rem <= '0;
      dv <= '0;
      q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt <= $bits(cnt)'(DIV_CYC);
      rem <= '0;
      dv <= divisor;
      q <= dividend;
    end else begin
      done <= busy && cnt == 1;
      if (busy) begin
        rem <= fit ? NW'(sh - {1'b0, dv}) : sh[NW-1:0];
        q <= {q[2*W-2:0], fit};
        cnt <= cnt - 1'b1;
        busy <= cnt != 1;
      end
    end
  end
endmodule

// File: rtl/batch_center.sv
// batch_center: buffers a batch of samples, divides out the mean, then streams each sample minus the mean (in_*: sample stream, out_*: centred stream, mean_out/num_out: batch stats)
module batch_center
  import spring_fxp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  fxp_t          in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output fxp_t          out_data,
  output logic          out_last,
  output fxp_t          mean_out,
  output logic [NW-1:0] num_out
);
  localparam int IW = $clog2(SIZE);
  bc_state_t state;
  fxp_t mem [SIZE];
  acc_t sum, sum_nx;
  logic [NW-1:0] count, count_nx;
  logic [IW-1:0] idx;
  logic [2*W-1:0] dividend;
  logic [W-1:0] quo;
  logic take, close, div_start, div_done, give;
  always_comb begin
    in_ready = state == LOAD && !rst;
    take = in_valid && in_ready;
    sum_nx = sum + acc_t'(in_data);
    count_nx = count + 1'b1;
    close = in_last || count_nx == NW'(SIZE);
    div_start = take && close;
    dividend = sum_nx[2*W-1] ? -sum_nx : sum_nx;
    out_valid = state == EMIT;
    out_last = out_valid && {1'b0, idx} == count - 1'b1;
    out_data = out_valid ? sat_fxp(acc_t'(mem[idx]) - acc_t'(mean_out)) : '0;
    give = out_valid && out_ready;
  end
  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (count_nx),
    .done     (div_done),
    .quotient (quo)
  );
  always_ff @(posedge clk)
    if (take) mem[count[IW-1:0]] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      count <= '0;
      sum <= '0;
      idx <= '0;
      mean_out <= '0;
      num_out <= '0;
    end else begin
      case (state)
        LOAD: if (take) begin
          sum <= sum_nx;
          count <= count_nx;
          if (close) state <= DIVIDE;
        end
        DIVIDE: if (div_done) begin
          mean_out <= sum[2*W-1] ? -quo : quo;
          num_out <= count;
          state <= EMIT;
        end
        EMIT: if (give) begin
          idx <= out_last ? '0 : idx + 1'b1;
          if (out_last) begin
            count <= '0;
            sum <= '0;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_batch_center.sv
// tb_batch_center: scoreboard bench for batch_center covering reset, centring, truncation, saturation, full batch, backpressure and mid-emit reset
module tb_batch_center;
  typedef logic signed [19:0] s20_t;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  s20_t in_data = 0;
  logic in_ready, out_valid, out_last;
  logic [19:0] out_data, mean_out;
  logic [4:0] num_out;
  int n_checks = 0, n_fail = 0, cyc = 0, t_last = 0;
  s20_t stim[$];
  logic [20:0] exp_q[$];
  batch_center dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .mean_out  (mean_out),
    .num_out   (num_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic feed(input bit use_last);
    longint sum = 0, m, d;
    foreach (stim[i]) sum += stim[i];
    m = sum / stim.size();
    foreach (stim[i]) begin
      d = stim[i] - m;
      d = d > 524287 ? 524287 : d < -524288 ? -524288 : d;
      exp_q.push_back({1'(i == stim.size() - 1), 20'(d)});
    end
    foreach (stim[i]) begin
      int g = 0;
      @(negedge clk);
      in_valid = 1;
      in_data = stim[i];
      in_last = use_last && i == stim.size() - 1;
      while (!in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      n_checks++;
      if (!in_ready) begin
        n_fail++;
        $display("FAIL feed_ready sample %0d: in_ready=%b want 1", i, in_ready);
      end
      @(posedge clk);
      #1 t_last = cyc;
    end
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_last} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags in_ready/out_valid/out_last=%b want 000", {in_ready, out_valid, out_last});
    end
    n_checks++;
    if (out_data !== 20'h0 || mean_out !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_data out_data=%h mean_out=%h want 0/0", out_data, mean_out);
    end
    n_checks++;
    if (num_out !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_num num_out=%0d want 0", num_out);
    end
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release in_ready=%b want 1", in_ready);
    end
  endtask
  task automatic test_basic;
    int g = 0;
    stim = '{20'h01000, 20'h02000, 20'h03000, 20'h04000};
    feed(1);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_in_ready_drop in_ready=%b want 0", in_ready);
    end
    while (exp_q.size() > 0 && g < 300) begin
      @(negedge clk);
      out_ready = 1;
      g++;
      if (out_valid) begin
        n_checks++;
        if ({out_last, out_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL basic_out got last=%b data=%h want last=%b data=%h", out_last, out_data, exp_q[0][20], exp_q[0][19:0]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_timeout %0d outputs missing want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_checks++;
    if (mean_out !== 20'h02800 || num_out !== 5'd4) begin
      n_fail++;
      $display("FAIL basic_mean mean_out=%h num_out=%0d want 02800/4", mean_out, num_out);
    end
  endtask
  task automatic test_trunc;
    int g = 0;
    stim = '{20'hFFFFF, 20'h00000};
    feed(1);
    while (exp_q.size() > 0 && g < 300) begin
      @(negedge clk);
      out_ready = 1;
      g++;
      if (out_valid) begin
        n_checks++;
        if ({out_last, out_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL trunc_out got last=%b data=%h want last=%b data=%h", out_last, out_data, exp_q[0][20], exp_q[0][19:0]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL trunc_timeout %0d outputs missing want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_checks++;
    if (mean_out !== 20'h00000 || num_out !== 5'd2) begin
      n_fail++;
      $display("FAIL trunc_mean mean_out=%h num_out=%0d want 00000/2", mean_out, num_out);
    end
  endtask
  task automatic test_saturate;
    int g = 0;
    stim = '{20'h7FFFF, 20'h80000, 20'h80000};
    feed(1);
    while (exp_q.size() > 0 && g < 300) begin
      @(negedge clk);
      out_ready = 1;
      g++;
      if (out_valid) begin
        n_checks++;
        if ({out_last, out_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sat_out got last=%b data=%h want last=%b data=%h", out_last, out_data, exp_q[0][20], exp_q[0][19:0]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sat_timeout %0d outputs missing want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_checks++;
    if (mean_out !== 20'hD5555 || num_out !== 5'd3) begin
      n_fail++;
      $display("FAIL sat_mean mean_out=%h num_out=%0d want D5555/3", mean_out, num_out);
    end
  endtask
  task automatic test_full;
    int g = 0;
    stim.delete();
    repeat (16) stim.push_back(20'h00100);
    feed(0);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_in_ready in_ready=%b want 0", in_ready);
    end
    while (exp_q.size() > 0 && g < 300) begin
      @(negedge clk);
      out_ready = 1;
      g++;
      if (out_valid) begin
        n_checks++;
        if ({out_last, out_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL full_out got last=%b data=%h want last=%b data=%h", out_last, out_data, exp_q[0][20], exp_q[0][19:0]);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_timeout %0d outputs missing want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_checks++;
    if (mean_out !== 20'h00100 || num_out !== 5'd16) begin
      n_fail++;
      $display("FAIL full_mean mean_out=%h num_out=%0d want 00100/16", mean_out, num_out);
    end
  endtask
  task automatic test_back_to_back;
    int g = 0, k = 0;
    bit first = 1;
    out_ready = 0;
    stim = '{20'h01000, 20'h02000, 20'h03000, 20'h04000};
    feed(1);
    while (exp_q.size() > 0 && g < 400) begin
      @(negedge clk);
      g++;
      if (out_valid) begin
        out_ready = k % 3 == 0;
        k++;
        if (first) begin
          first = 0;
          n_checks++;
          if (cyc - t_last != 41) begin
            n_fail++;
            $display("FAIL bp_latency first out_valid %0d cycles after last input, want 41", cyc - t_last);
          end
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_overlap in_ready=%b during EMIT want 0", in_ready);
        end
        n_checks++;
        if ({out_last, out_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL bp_out got last=%b data=%h want last=%b data=%h", out_last, out_data, exp_q[0][20], exp_q[0][19:0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || first) begin
      n_fail++;
      $display("FAIL bp_timeout %0d outputs missing want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    out_ready = 1;
  endtask
  task automatic test_reset_emit;
    int g = 0;
    stim = '{20'h01000, 20'h02000, 20'h03000, 20'h04000};
    feed(1);
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL rst_emit_reach out_valid=%b want 1", out_valid);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b00 || out_data !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_emit_clear out_valid/in_ready=%b out_data=%h want 00/00000", {out_valid, in_ready}, out_data);
    end
    rst = 0;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || mean_out !== 20'h0 || num_out !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_emit_release in_ready=%b mean_out=%h num_out=%0d want 1/00000/0", in_ready, mean_out, num_out);
    end
    g = 0;
    stim = '{20'h00800};
    feed(1);
    while (exp_q.size() > 0 && g < 300) begin
      @(negedge clk);
      out_ready = 1;
      g++;
      if (out_valid) begin
        n_checks++;
        if ({out_last, out_data} !== 21'h100000) begin
          n_fail++;
          $display("FAIL rst_emit_fresh got last=%b data=%h want last=1 data=00000", out_last, out_data);
        end
        void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_emit_timeout %0d outputs missing want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    n_checks++;
    if (mean_out !== 20'h00800 || num_out !== 5'd1) begin
      n_fail++;
      $display("FAIL rst_emit_mean mean_out=%h num_out=%0d want 00800/1", mean_out, num_out);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_trunc();
    test_saturate();
    test_full();
    test_back_to_back();
    test_reset_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
